cp_insert_buffer_tx: RTL and testbench
======================================

Name: cp_insert_buffer_tx

Overview:
TX-side ping-pong sample buffer between the WIFI IFFT output and the DAC/front-end path. It accepts 64-sample OFDM symbols from the IFFT and emits each symbol as 80 samples, in this order:
- the 16-sample cyclic prefix (samples 48..63),
- then the full body (samples 0..63).
Two banks let the IFFT write symbol k+1 while symbol k is read out.

Parameters:
- DATA, 24, sample width (I and Q concatenated, 12 bits each).
- N, 64, samples per symbol (power of 2).
- CP, 16, cyclic prefix length (CP < N).
- AW, 6, log2(N).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- we  in  1  write strobe; one sample per cycle
- data_in  in  DATA  IFFT output sample, natural order 0..N-1
- in_ready  out  1  write bank available; writes accepted only while high
- re  in  1  downstream pacing; one output sample per cycle while high
- data_out  out  DATA  registered output sample
- valid_out  out  1  data_out valid this cycle
- sym_start  out  1  high with the first CP sample of each symbol
- overflow  out  1  sticky write-drop flag (see Optional Feature)

Behaviour:
Reset values:
- all outputs 0, except in_ready = 1.
- wr_bank = 0, rd_bank = 0, bank_full[1:0] = 0, write/read counters = 0, FSM in IDLE.

Write side:
- Accepted write = we && in_ready. It stores to bank wr_bank at address wr_cnt, then wr_cnt increments.
- At wr_cnt = N-1 with an accepted write: bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
- in_ready = !bank_full[wr_bank] (combinational).
- A we arriving while in_ready = 0 is dropped and no counter moves.

Read FSM (IDLE, CP, BODY):
- IDLE: when bank_full[rd_bank] = 1, go to CP with rd_cnt = N-CP.
- CP: each cycle with re = 1, read address rd_cnt and increment it. After address N-1 is read, go to BODY with rd_cnt = 0.
- BODY: each cycle with re = 1, read address rd_cnt and increment it. After address N-1 is read:
  - clear bank_full[rd_bank] and toggle rd_bank;
  - if the other bank is already full, go directly to CP (back-to-back symbols, no gap cycle); otherwise go to IDLE.
- re = 0 in CP or BODY freezes the counters; no sample is lost.

Output timing:
- Latency: data_out and valid_out appear 1 cycle after the read cycle (registered RAM read).
- valid_out = read performed in the previous cycle.
- sym_start is registered alongside the CP read of address N-CP.
- data_out holds its last value when valid_out = 0.

Boundary conditions:
- Empty: a symbol is never read until all N of its samples are written. A partial bank never starts the FSM.
- Simultaneous events: a bank-full set (write side) and a bank-free clear (read side) on different banks in the same cycle both take effect. The same bank can never be set and cleared in the same cycle.
- Wrap-around: the counters are AW bits. The CP start address N-CP is loaded explicitly; no modular arithmetic is relied on beyond the N-1 → 0 wrap.
- Reset mid-symbol: everything returns to reset values, any partial symbol is discarded, and no sample is emitted after reset deasserts until a new full symbol is written.

Optional Feature:
Macro: CP_TX_OVERFLOW_FLAG_EN
- Defined: overflow is set on any cycle with we = 1 && in_ready = 0, and stays set until reset.
- Undefined: overflow is tied to 0 and the flag register is not built.
- Datapath behaviour is identical either way.

Decomposition:
Shared package (wifi_tx_pkg):
- constants N, CP, AW, DATA;
- read FSM state encoding: IDLE = 2'd0, CP = 2'd1, BODY = 2'd2.

Sub-module tx_bank_ram:
- simple dual-port RAM, depth 2*N, address {bank, addr};
- synchronous write;
- read registered, with reset of data_out to 0 and read enable re.
- The top level holds the counters, bank flags and FSM.

Test Plan:
1. Write samples 0..63 (value = index) with re held at 1. Response: first valid_out 2 cycles after the last write. Output order is 48..63 then 0..63 (80 valid cycles). sym_start is high only with value 48.
2. Stream 3 symbols back-to-back with re = 1. Response: 240 consecutive valid_out cycles with no gap, and in_ready never drops below what the IFFT needs after the first bank fills.
3. Fill both banks with re = 0. Response: in_ready = 0 after sample 128. A 129th we is dropped and overflow = 1 (with the macro). The bank contents are unchanged.
4. Toggle re 1,0,1,0 during CP. Response: output values are still contiguous (48, 49, 50...), and valid_out follows re delayed by 1 cycle.
5. Assert reset after 40 samples of BODY output. Response: all outputs 0 and in_ready = 1. A new symbol of value 100 + index then outputs 148..163, 100..163.
6. Write 63 samples only. Response: valid_out stays 0 indefinitely and in_ready stays 1.

Source files
------------

// File: rtl/wifi_tx_pkg.sv
// Shared constants and read-FSM encoding for the WIFI TX cyclic-prefix buffer.
package wifi_tx_pkg;

    localparam int DATA = 24;
    localparam int N    = 64;
    localparam int CP   = 16;
    localparam int AW   = 6;

    localparam logic [AW-1:0] CP_START = AW'(N - CP);
    localparam logic [AW-1:0] LAST     = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CP   = 2'd1,
        S_BODY = 2'd2
    } rd_state_e;

endpackage

// File: rtl/tx_bank_ram.sv
// Two-bank sample RAM: synchronous write, registered read with enable.
module tx_bank_ram
    import wifi_tx_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW:0]     waddr,
    input  logic [DATA-1:0] wdata,
    input  logic            re,
    input  logic [AW:0]     raddr,
    output logic [DATA-1:0] rdata
);

    logic [DATA-1:0] mem [2*N];
    logic [DATA-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cp_insert_buffer_tx.sv
// Ping-pong TX buffer emitting each 64-sample symbol as CP(48..63) + body(0..63).
// Optional sticky write-drop flag: define CP_TX_OVERFLOW_FLAG_EN.
module cp_insert_buffer_tx
    import wifi_tx_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [DATA-1:0] data_in,
    output logic            in_ready,
    input  logic            re,
    output logic [DATA-1:0] data_out,
    output logic            valid_out,
    output logic            sym_start,
    output logic            overflow
);

    rd_state_e     state_q, state_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          valid_q, valid_d;
    logic          sym_q, sym_d;
    logic          wr_acc;
    logic          rd_fire;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_acc   = we && in_ready;
    assign rd_fire  = (state_q != S_IDLE) && re;

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        valid_d   = rd_fire;
        sym_d     = rd_fire && (state_q == S_CP) && (rd_cnt_q == CP_START);

        if (wr_acc) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = S_CP;
                    rd_cnt_d = CP_START;
                end
            end
            S_CP: begin
                if (re) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST) begin
                        state_d  = S_BODY;
                        rd_cnt_d = '0;
                    end
                end
            end
            S_BODY: begin
                if (re) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        // Back-to-back symbols skip IDLE so there is no gap
                        if (full_q[~rd_bank_q]) begin
                            state_d  = S_CP;
                            rd_cnt_d = CP_START;
                        end else begin
                            state_d  = S_IDLE;
                            rd_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            valid_q   <= 1'b0;
            sym_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            valid_q   <= valid_d;
            sym_q     <= sym_d;
        end
    end

    tx_bank_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr ({wr_bank_q, wr_cnt_q}),
        .wdata (data_in),
        .re    (rd_fire),
        .raddr ({rd_bank_q, rd_cnt_q}),
        .rdata (data_out)
    );

    assign valid_out = valid_q;
    assign sym_start = sym_q;

`ifdef CP_TX_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q || (we && !in_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cp_insert_buffer_tx.sv
// Directed bench for cp_insert_buffer_tx: order, latency, streaming, backpressure, reset.
module tb_cp_insert_buffer_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [23:0] data_in = '0;
    logic        in_ready;
    logic        re = 1'b0;
    logic [23:0] data_out;
    logic        valid_out;
    logic        sym_start;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_done_cyc = 0;

    logic [23:0] outq[$];
    logic        ssq[$];
    int          cycq[$];

`ifdef CP_TX_OVERFLOW_FLAG_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    cp_insert_buffer_tx dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .re        (re),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sym_start (sym_start),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset && valid_out) begin
            outq.push_back(data_out);
            ssq.push_back(sym_start);
            cycq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        we = 1'b0;
        re = 1'b0;
        repeat (2) @(negedge clk);
        outq.delete();
        ssq.delete();
        cycq.delete();
        reset = 1'b1;
    endtask

    task automatic wr(input int base, input int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 5000) begin
            @(negedge clk);
            data_in = 24'(base + i);
            we = 1'b1;
            if (in_ready) i++;
            guard++;
        end
        @(negedge clk);
        we = 1'b0;
        wr_done_cyc = cyc;
        chk("wr count", i, n);
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, outq.size(), n);
    endtask

    function automatic int exp_val(input int base, input int i);
        return (i < 16) ? base + 48 + i : base + i - 16;
    endfunction

    task automatic check_sym(input string tag, input int base, input int off);
        for (int i = 0; i < 80; i++) begin
            if (off + i < outq.size()) begin
                chk({tag, " data"}, outq[off+i], exp_val(base, i));
                chk({tag, " sym"}, ssq[off+i], (i == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int gaps;
        logic prev;
        logic pat [8];

        // Reset state
        #1;
        chk("rst data", data_out, 0);
        chk("rst valid", valid_out, 0);
        chk("rst sym", sym_start, 0);
        chk("rst ovf", overflow, 0);
        chk("rst ready", in_ready, 1);
        do_reset();

        // 1: single symbol, order and latency
        re = 1'b1;
        wr(0, 64);
        wait_out("t1 cnt", 80, 300);
        if (cycq.size() > 0) chk("t1 latency", cycq[0] - wr_done_cyc, 2);
        check_sym("t1", 0, 0);
        repeat (20) @(negedge clk);
        chk("t1 no extra", outq.size(), 80);

        // 2: three back-to-back symbols
        do_reset();
        re = 1'b1;
        wr(24'h100, 64);
        wr(24'h200, 64);
        wr(24'h300, 64);
        wait_out("t2 cnt", 240, 600);
        gaps = 0;
        for (int i = 1; i < cycq.size(); i++)
            if (cycq[i] != cycq[i-1] + 1) gaps++;
        chk("t2 gaps", gaps, 0);
        check_sym("t2 s0", 24'h100, 0);
        check_sym("t2 s1", 24'h200, 80);
        check_sym("t2 s2", 24'h300, 160);

        // 3: both banks full, dropped write
        do_reset();
        wr(24'h400, 64);
        wr(24'h500, 64);
        chk("t3 ready", in_ready, 0);
        @(negedge clk);
        data_in = 24'hDEAD;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        chk("t3 ovf", overflow, EXP_OVF);
        chk("t3 no out", outq.size(), 0);
        re = 1'b1;
        wait_out("t3 cnt", 160, 400);
        check_sym("t3 s0", 24'h400, 0);
        check_sym("t3 s1", 24'h500, 80);
        chk("t3 ready2", in_ready, 1);

        // 4: re toggling during CP
        do_reset();
        wr(24'h600, 64);
        repeat (3) @(negedge clk);
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t4 valid", valid_out, prev);
            prev = pat[k];
            re = pat[k];
            @(negedge clk);
        end
        chk("t4 valid end", valid_out, prev);
        re = 1'b1;
        wait_out("t4 cnt", 80, 300);
        check_sym("t4", 24'h600, 0);

        // 5: reset in the middle of BODY output
        do_reset();
        re = 1'b1;
        wr(24'h700, 64);
        wait_out("t5 pre", 56, 300);
        reset = 1'b0;
        #1;
        chk("t5 data", data_out, 0);
        chk("t5 valid", valid_out, 0);
        chk("t5 sym", sym_start, 0);
        chk("t5 ovf", overflow, 0);
        chk("t5 ready", in_ready, 1);
        repeat (2) @(negedge clk);
        outq.delete();
        ssq.delete();
        cycq.delete();
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("t5 quiet", outq.size(), 0);
        wr(100, 64);
        wait_out("t5 cnt", 80, 300);
        check_sym("t5", 100, 0);

        // 6: partial symbol never starts output
        do_reset();
        re = 1'b1;
        wr(24'h800, 63);
        repeat (150) @(negedge clk);
        chk("t6 no out", outq.size(), 0);
        chk("t6 valid", valid_out, 0);
        chk("t6 ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
